// File: rtl/data_mem_responder_pkg.sv
// Shared processor package: data-memory word width, default sizing and responder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_responder_pkg;

    localparam int DMEM_WORD_W        = 16;
    localparam int DMEM_DEPTH_DEFAULT = 256;
    localparam int DMEM_WAIT_DEFAULT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Widen a loaded byte to a full word, optionally replicating its sign bit.
    function automatic logic [DMEM_WORD_W-1:0] byte_extend(input logic [7:0] b, input logic sgn);
        return {(sgn ? {8{b[7]}} : 8'h00), b};
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word array: synchronous byte-lane write, combinational read, one shared address.
// Latency: read is combinational; a write lands on the clock edge it is enabled for.
// Backpressure: none; the owner decides when to write.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int  DEPTH = DMEM_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic                   clk,
    input  logic [1:0]             be,
    input  logic [AW-1:0]          addr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH];

    // Per-lane writes; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one load/store at a time over a 16-bit word array (byte lanes with DMEM_BYTE_ACCESS_EN).
// Latency: response valid WAIT+1 cycles after the request cycle; next request earliest WAIT+2 cycles later.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, busy high throughout.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEFAULT,
    parameter int WAIT  = DMEM_WAIT_DEFAULT
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [15:0]            req_addr,
    input  logic [DMEM_WORD_W-1:0] req_wdata,
    input  logic                   req_byte,
    input  logic                   req_signed,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DMEM_WORD_W-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   busy
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [15:0] DEPTH_LIM = 16'(DEPTH);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        do_access;

    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    logic        acc_we;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        oob;
    logic [1:0]  lane_be;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] load_data;

`ifdef DMEM_BYTE_ACCESS_EN
    logic byte_q;
    logic signed_q;
    logic acc_byte;
    logic acc_signed;
`else
    logic unused_byte_ctl;
    assign unused_byte_ctl = ^{req_byte, req_signed, acc_addr[0]};
`endif

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake outputs and the single-cycle access strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        do_access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    cnt_d = WAIT_LOAD;
                    if (WAIT == 0) begin
                        // No wait states: the access happens on the accept edge itself.
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                // Returning to IDLE first keeps a new request out of the handshake cycle.
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request on accept; later req_* activity is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= 16'd0;
            wdata_q  <= 16'd0;
`ifdef DMEM_BYTE_ACCESS_EN
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
`endif
        end else if (state_q == ST_IDLE && req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
            byte_q   <= req_byte;
            signed_q <= req_signed;
`endif
        end
    end

    // In IDLE the only possible access is the zero-wait one, which uses the live request.
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
`ifdef DMEM_BYTE_ACCESS_EN
    assign acc_byte   = (state_q == ST_IDLE) ? req_byte   : byte_q;
    assign acc_signed = (state_q == ST_IDLE) ? req_signed : signed_q;
`endif

    assign oob = ({1'b0, acc_addr[15:1]} >= DEPTH_LIM);

    // Byte-lane steering for writes and lane select / extension for reads.
    always_comb begin
        lane_be   = 2'b11;
        mem_wdata = acc_wdata;
        load_data = mem_rdata;
`ifdef DMEM_BYTE_ACCESS_EN
        if (acc_byte) begin
            mem_wdata = {acc_wdata[7:0], acc_wdata[7:0]};
            if (acc_addr[0]) begin
                lane_be   = 2'b10;
                load_data = byte_extend(mem_rdata[15:8], acc_signed);
            end else begin
                lane_be   = 2'b01;
                load_data = byte_extend(mem_rdata[7:0], acc_signed);
            end
        end
`endif
        mem_be = (do_access && acc_we && !oob) ? lane_be : 2'b00;
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .be    (mem_be),
        .addr  (acc_addr[AW:1]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Response payload is latched once, on the edge entering RESP, and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata <= 16'd0;
            resp_err   <= 1'b0;
        end else if (do_access) begin
            resp_err   <= oob;
            resp_rdata <= (oob || acc_we) ? 16'd0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we, req_byte, req_signed;
    logic [15:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_ready, resp_err, busy;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_byte, b_req_signed;
    logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;

    logic [16:0] sb[$];
    logic [16:0] sb_b[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_d;

    logic [15:0] b_addr_tbl [4] = '{16'h0100, 16'h0102, 16'h0104, 16'h0106};
    logic [15:0] b_dat_tbl  [4] = '{16'h1357, 16'h2468, 16'h8001, 16'h7FFE};

    data_mem_responder #(.DEPTH(256), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH(256), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_byte(b_req_byte), .req_signed(b_req_signed),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .busy(b_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request when ready; returns #1 after the accept edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic byt, input logic sgn, input logic [15:0] exp_d, input logic exp_e);
        int n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("issue_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_byte = byt; req_signed = sgn;
        sb.push_back({exp_e, exp_d});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; waits for the response and scores it.
    task automatic collect(input string tag, input int exp_lat);
        int          lat = 1;
        logic [16:0] e;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, {16'd0, resp_rdata}, {16'd0, e[15:0]});
            check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e[16]});
            last_d = e[15:0];
        end
        if (resp_ready) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic byt, input logic sgn, input logic [15:0] exp_d, input logic exp_e);
        issue(we, addr, wdata, byt, sgn, exp_d, exp_e);
        collect(tag, 3);
    endtask

    task automatic b_score(input string tag);
        logic [16:0] e;
        check({tag, "_vld"}, {31'd0, b_resp_valid}, 32'd1);
        check({tag, "_sb"}, 32'(sb_b.size() != 0), 32'd1);
        if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            check({tag, "_rdata"}, {16'd0, b_resp_rdata}, {16'd0, e[15:0]});
            check({tag, "_err"}, {31'd0, b_resp_err}, {31'd0, e[16]});
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_byte = 0; req_signed = 0;
        resp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_byte = 0; b_req_signed = 0;
        b_resp_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rdata", {16'd0, resp_rdata}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_b_resp_valid", {31'd0, b_resp_valid}, 32'd0);

        // Store then load, WAIT=2
        txn("st_beef", 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0);
        txn("ld_beef", 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 0);

        // Response held under backpressure; new request ignored until after the handshake
        resp_ready = 0;
        issue(0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 0);
        collect("stall_ld", 3);
        req_valid = 1; req_we = 0; req_addr = 16'h0010; req_byte = 0; req_signed = 0;
        sb.push_back({1'b0, 16'hBEEF});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_vld", {31'd0, resp_valid}, 32'd1);
            check("stall_rdata", {16'd0, resp_rdata}, {16'd0, last_d});
            check("stall_busy", {31'd0, busy}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        check("release_busy", {31'd0, busy}, 32'd0);
        check("release_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("release_accept_busy", {31'd0, busy}, 32'd1);
        req_valid = 0;
        collect("post_stall", 3);

        // Address range boundaries
        txn("st_w0", 1, 16'h0000, 16'h0C0C, 0, 0, 16'h0000, 0);
        txn("st_top", 1, 16'h01FE, 16'h7777, 0, 0, 16'h0000, 0);
        txn("ld_top", 0, 16'h01FE, 16'h0000, 0, 0, 16'h7777, 0);
        txn("ld_oob", 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 1);
        txn("st_oob", 1, 16'h0200, 16'h1111, 0, 0, 16'h0000, 1);
        txn("ld_oob_max", 0, 16'hFFFE, 16'h0000, 0, 0, 16'h0000, 1);
        txn("ld_w0_after_oob", 0, 16'h0000, 16'h0000, 0, 0, 16'h0C0C, 0);
        txn("ld_top_after_oob", 0, 16'h01FE, 16'h0000, 0, 0, 16'h7777, 0);
        txn("ld_10_after_oob", 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 0);

        // Byte lanes / ignored addr[0]
        txn("st_1234", 1, 16'h0020, 16'h1234, 0, 0, 16'h0000, 0);
`ifdef DMEM_BYTE_ACCESS_EN
        txn("st_byte_hi", 1, 16'h0021, 16'h00F0, 1, 0, 16'h0000, 0);
        txn("ld_word_f034", 0, 16'h0020, 16'h0000, 0, 0, 16'hF034, 0);
        txn("ld_byte_signed", 0, 16'h0021, 16'h0000, 1, 1, 16'hFFF0, 0);
        txn("ld_byte_unsigned", 0, 16'h0021, 16'h0000, 1, 0, 16'h00F0, 0);
        txn("ld_byte_lo_signed", 0, 16'h0020, 16'h0000, 1, 1, 16'h0034, 0);
        txn("st_byte_lo", 1, 16'h0020, 16'h5A80, 1, 0, 16'h0000, 0);
        txn("ld_byte_lo_neg", 0, 16'h0020, 16'h0000, 1, 1, 16'hFF80, 0);
        txn("ld_word_f080", 0, 16'h0020, 16'h0000, 0, 0, 16'hF080, 0);
`else
        txn("st_odd_word", 1, 16'h0021, 16'hABCD, 1, 0, 16'h0000, 0);
        txn("ld_even_word", 0, 16'h0020, 16'h0000, 0, 0, 16'hABCD, 0);
        txn("ld_odd_byteflags", 0, 16'h0021, 16'h0000, 1, 1, 16'hABCD, 0);
`endif

        // WAIT=0 instance: stores, then back-to-back loads every 2 cycles
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1; b_req_we = 1; b_req_addr = b_addr_tbl[i]; b_req_wdata = b_dat_tbl[i];
            sb_b.push_back({1'b0, 16'h0000});
            @(posedge clk); #1;
            b_req_valid = 0;
            b_score("w0_store");
            @(posedge clk); #1;
        end
        b_req_we = 0; b_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            b_req_addr = b_addr_tbl[i];
            sb_b.push_back({1'b0, b_dat_tbl[i]});
            @(posedge clk); #1;
            b_score("w0_load");
            check("w0_load_busy", {31'd0, b_busy}, 32'd1);
            @(posedge clk); #1;
            check("w0_gap_vld", {31'd0, b_resp_valid}, 32'd0);
            check("w0_gap_ready", {31'd0, b_req_ready}, 32'd1);
        end
        b_req_valid = 0;

        // Reset during the wait states of a store abandons it
        txn("st_5555", 1, 16'h0030, 16'h5555, 0, 0, 16'h0000, 0);
        txn("ld_pre_rst", 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 0);
        req_valid = 1; req_we = 1; req_addr = 16'h0030; req_wdata = 16'hAAAA; req_byte = 0; req_signed = 0;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_rdata", {16'd0, resp_rdata}, 32'd0);
        check("arst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        txn("ld_after_rst", 0, 16'h0030, 16'h0000, 0, 0, 16'h5555, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
